otp_block_sequencer: RTL
========================

# otp_block_sequencer

Sequences the 16-bit XOR block-cryptor datapath across a full 240-bit message. It latches a message/key pair on a start handshake and streams 15 16-bit slices through the single registered cryptor instance. It collects the one-cycle-delayed results and presents the assembled 240-bit ciphertext with a done pulse. It sits between the message source and the cryptor block and is the only driver of the cryptor's inputs.

## Interface
- KEY_SIZE, 16, slice width (bits) of the cryptor datapath
- MSG_SIZE, 240, full message/key width; must be an integer multiple of KEY_SIZE
- NBLK (derived, localparam), MSG_SIZE/KEY_SIZE = 15, slice count
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- msg  input  MSG_SIZE  plaintext; latched when start accepted
- key  input  MSG_SIZE  key; latched when start accepted
- busy  output  1  high in RUN, DRAIN, DONE
- done  output  1  one-cycle pulse; cipher complete
- cipher  output  MSG_SIZE  assembled ciphertext, registered
- blk_msg  output  KEY_SIZE  slice to cryptor msg input
- blk_key  output  KEY_SIZE  slice to cryptor key input
- blk_out  input  KEY_SIZE  cryptor registered output
- blk_idx  output  4  index of slice currently driven

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → latch msg/key into msg_r/key_r, clear cipher to 0, idx←0, go RUN. start=0 → stay.
- RUN (idx=k):
  - blk_msg = msg_r[k*KEY_SIZE +: KEY_SIZE]; blk_key likewise from key_r; blk_idx=k.
  - If k≥1, capture blk_out into cipher slot k−1 at cycle end.
  - k<NBLK−1 → idx←k+1. k=NBLK−1 → go DRAIN.
- DRAIN: capture blk_out into slot NBLK−1. Go DONE.
  - blk_msg/blk_key hold the last slice; blk_idx=NBLK−1.
- DONE: done=1 for exactly this cycle. Go IDLE.
- Outside RUN/DRAIN, blk_msg, blk_key and blk_idx are 0.
- Slot j = cipher[j*KEY_SIZE +: KEY_SIZE]. Slice 0 is the LSBs.
- start while busy is ignored: no queueing, no latch of msg/key.
- msg/key may change freely after acceptance; only latched copies are used.
- cipher holds its value after DONE until the next accepted start clears it.
- idx width fixed at 4 bits. It never exceeds NBLK−1 and never wraps.

## Timing
- Reset (async assert, any state): state IDLE, idx 0, busy 0, done 0, cipher 0, blk_msg/blk_key/blk_idx 0, msg_r/key_r 0.
- Reset mid-operation: no done pulse; partial cipher discarded.
- The cryptor registers its inputs on each rising edge. blk_out for slice k is therefore valid during the cycle after slice k is driven, and is sampled on that cycle's closing edge.
- blk_out must be stable before the next rising edge. Sub-cycle settling delay is tolerated.
- Edge 0 samples start=1.
  - Cycles 1..15: RUN, idx 0..14.
  - Cycle 16: DRAIN.
  - Cycle 17: DONE, done=1.
- Start-to-done latency is NBLK+2 = 17 cycles.
- Earliest next accept is at the edge closing cycle 18 (IDLE). Throughput is one message per 18 cycles with start held high.
- busy rises in cycle 1 and falls in cycle 18.
- cipher bits become final progressively. The full value is guaranteed only from the done cycle onward.

## Test plan
- Reset then idle 5 cycles → busy=0, done=0, cipher=0, blk_msg/blk_key=0.
- Uniform message: every msg slice 0xAAAA, every key slice 0x5555, start one cycle → done exactly 17 cycles after the accepting edge; cipher all 0xFFFF; busy high for 17 cycles.
- Indexed slices: msg slice j = 0x0100·j, key slice j = 0x00F0+j → each cipher slot j = (0x0100·j)^(0x00F0+j). Also check blk_idx steps 0..14 and blk_msg matches slice j in each RUN cycle.
- Start during busy: pulse start with different msg at cycles 5 and 17 → ignored; cipher matches the first message only; exactly one done.
- Back-to-back: start held high across two messages → second accept on the edge closing the first IDLE cycle after DONE; two done pulses 18 cycles apart; second cipher correct.
- Async reset asserted mid-RUN (idx=7) → immediate IDLE with all outputs 0 and no done pulse. A new start after deassert completes normally in 17 cycles.

Source files
------------

// File: rtl/otp_block_sequencer.sv
// Streams a latched MSG_SIZE-bit message/key pair through a KEY_SIZE-bit registered
// XOR cryptor one slice at a time and assembles the returned slices into the ciphertext.
module otp_block_sequencer #(
   parameter int unsigned KEY_SIZE = 16,
   parameter int unsigned MSG_SIZE = 240
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [MSG_SIZE-1:0] i_msg,
   input  logic [MSG_SIZE-1:0] i_key,
   output logic                o_busy,
   output logic                o_done,
   output logic [MSG_SIZE-1:0] o_cipher,
   output logic [KEY_SIZE-1:0] o_blk_msg,
   output logic [KEY_SIZE-1:0] o_blk_key,
   input  logic [KEY_SIZE-1:0] i_blk_out,
   output logic [3:0]          o_blk_idx
);

   localparam int unsigned NBLK     = MSG_SIZE / KEY_SIZE;
   localparam logic [3:0]  LAST_IDX = 4'(NBLK - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [3:0]          r_idx;
   logic [MSG_SIZE-1:0] r_msg;
   logic [MSG_SIZE-1:0] r_key;
   logic [MSG_SIZE-1:0] r_cipher;
   logic                w_accept;
   logic                w_capture;
   logic [3:0]          w_cap_idx;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (i_start) w_state_next = StRun;
         StRun:   if (r_idx == LAST_IDX) w_state_next = StDrain;
         StDrain: w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // The cryptor output lags the driven slice by one cycle, so RUN captures slot idx-1.
   always_comb begin
      w_accept  = (r_state == StIdle) && i_start;
      w_capture = 1'b0;
      w_cap_idx = 4'd0;
      if (r_state == StRun && r_idx != 4'd0) begin
         w_capture = 1'b1;
         w_cap_idx = r_idx - 4'd1;
      end else if (r_state == StDrain) begin
         w_capture = 1'b1;
         w_cap_idx = LAST_IDX;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx    <= 4'd0;
         r_msg    <= '0;
         r_key    <= '0;
         r_cipher <= '0;
      end else begin
         if (w_accept) begin
            r_idx    <= 4'd0;
            r_msg    <= i_msg;
            r_key    <= i_key;
            r_cipher <= '0;
         end else if (r_state == StRun && r_idx != LAST_IDX) begin
            r_idx <= r_idx + 4'd1;
         end
         if (w_capture) begin
            r_cipher[w_cap_idx*KEY_SIZE +: KEY_SIZE] <= i_blk_out;
         end
      end
   end

   always_comb begin
      o_busy    = (r_state != StIdle);
      o_done    = (r_state == StDone);
      o_cipher  = r_cipher;
      o_blk_msg = '0;
      o_blk_key = '0;
      o_blk_idx = 4'd0;
      if (r_state == StRun || r_state == StDrain) begin
         o_blk_msg = r_msg[r_idx*KEY_SIZE +: KEY_SIZE];
         o_blk_key = r_key[r_idx*KEY_SIZE +: KEY_SIZE];
         o_blk_idx = r_idx;
      end
   end

endmodule
